// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared types for the MEM-stage load/store issue unit: memory op codes,
//   bus size codes, the data-bus request/response structs, and helpers for
//   decoding size, alignment and building the outgoing request.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_SB, MOP_SH, MOP_SW
  } mem_op_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  function automatic logic op_is_store(mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  function automatic msize_t op_size(mem_op_t op);
    msize_t s;
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: s = MSIZE1;
      MOP_LH, MOP_LHU, MOP_SH: s = MSIZE2;
      default:                 s = MSIZE4;
    endcase
    return s;
  endfunction

  function automatic logic op_aligned(mem_op_t op, logic [1:0] off);
    logic ok;
    case (op_size(op))
      MSIZE1:  ok = 1'b1;
      MSIZE2:  ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  // Loads carry zero strobe and zero data; stores replicate the source
  // value across every lane so the strobe alone selects the target bytes.
  function automatic dbus_req_t build_req(mem_op_t op, logic [31:0] addr,
                                          logic [31:0] wdata);
    dbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.addr  = addr;
    r.size  = op_size(op);
    if (op_is_store(op)) begin
      case (op_size(op))
        MSIZE1: begin
          r.strobe = 4'b0001 << addr[1:0];
          r.data   = {4{wdata[7:0]}};
        end
        MSIZE2: begin
          r.strobe = 4'b0011 << addr[1:0];
          r.data   = {2{wdata[15:0]}};
        end
        default: begin
          r.strobe = 4'b1111;
          r.data   = wdata;
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the MEM-stage instruction inputs, the pipeline control outputs
//   and the data bus towards the MMU.
//   slave  : the issue unit (consumes instruction + dresp, drives dreq/status)
//   master : the pipeline/MMU side
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic        in_valid;
  mem_op_t     in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        flush;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, flush, dresp,
    output dreq, stall, done, rdata, adel, ades
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, flush, dresp,
    input  dreq, stall, done, rdata, adel, ades
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align
//   Combinational load-data alignment: moves the addressed byte/half to
//   bit 0 and sign- or zero-extends it according to the op.
//   i_op   : load op code
//   i_off  : byte offset within the word
//   i_raw  : raw word from the data bus
//   o_data : extended result
module load_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_t     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;

  assign w_shift = i_raw >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shift;
    case (i_op)
      MOP_LB:  o_data = {{24{w_shift[7]}}, w_shift[7:0]};
      MOP_LBU: o_data = {24'd0, w_shift[7:0]};
      MOP_LH:  o_data = {{16{w_shift[15]}}, w_shift[15:0]};
      MOP_LHU: o_data = {16'd0, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store issue unit. Issues one data-bus request per memory
//   instruction, holds it through the addr_ok/data_ok handshake, stalls the
//   pipeline until completion, extracts load data and flags address errors.
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : instruction inputs, dbus request/response, stall/done/rdata/adel/ades
//
//   state  | meaning
//   IDLE   | no access outstanding; request driven straight from the inputs
//   REQ    | request registered, waiting for addr_ok
//   WAIT   | address accepted, waiting for data_ok
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_next;
  dbus_req_t   r_req;
  mem_op_t     r_op;
  logic [1:0]  r_off;
  logic        r_drop;

  logic        w_idle, w_live, w_aligned, w_issue, w_misal;
  logic        w_retire, w_quiet, w_done;
  dbus_req_t   w_new_req, w_dreq;
  mem_op_t     w_ld_op;
  logic [1:0]  w_ld_off;
  logic [31:0] w_ld_data;

  assign w_idle    = (r_state == S_IDLE);
  assign w_live    = bus.in_valid & ~bus.flush;
  assign w_aligned = op_aligned(bus.in_op, bus.in_addr[1:0]);
  assign w_issue   = resetn & w_idle & w_live & w_aligned;
  assign w_misal   = resetn & w_idle & w_live & ~w_aligned;
  assign w_new_req = build_req(bus.in_op, bus.in_addr, bus.in_wdata);

  // Same-cycle completion in IDLE uses the live op; later ones the captured op.
  assign w_ld_op  = w_idle ? bus.in_op : r_op;
  assign w_ld_off = w_idle ? bus.in_addr[1:0] : r_off;

  load_align u_load_align (
    .i_op   (w_ld_op),
    .i_off  (w_ld_off),
    .i_raw  (bus.dresp.data),
    .o_data (w_ld_data)
  );

  always_comb begin
    w_next   = r_state;
    w_dreq   = '0;
    w_retire = 1'b0;
    if (resetn) begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            w_dreq = w_new_req;
            if (bus.dresp.addr_ok && bus.dresp.data_ok) w_retire = 1'b1;
            else if (bus.dresp.addr_ok)                 w_next   = S_WAIT;
            else                                        w_next   = S_REQ;
          end
        end
        S_REQ: begin
          w_dreq = r_req;
          if (bus.dresp.addr_ok) begin
            if (bus.dresp.data_ok) begin
              w_next   = S_IDLE;
              w_retire = 1'b1;
            end else begin
              w_next = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.dresp.data_ok) begin
            w_next   = S_IDLE;
            w_retire = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // A flush arriving in the completion cycle also kills that completion.
  assign w_quiet = ~w_idle & (r_drop | bus.flush);
  assign w_done  = w_misal | (w_retire & ~w_quiet);

  assign bus.dreq  = w_dreq;
  assign bus.done  = w_done;
  assign bus.stall = resetn & ~w_done & (~w_idle | w_live);
  assign bus.rdata = (w_done & ~w_misal & ~op_is_store(w_ld_op)) ? w_ld_data : 32'd0;
  assign bus.adel  = w_misal & ~op_is_store(bus.in_op);
  assign bus.ades  = w_misal &  op_is_store(bus.in_op);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_op    <= MOP_LB;
      r_off   <= 2'b00;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_req <= w_new_req;
        r_op  <= bus.in_op;
        r_off <= bus.in_addr[1:0];
      end
      r_drop <= ~w_idle & (w_next != S_IDLE) & (r_drop | bus.flush);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed scenarios with hand-computed expectations, followed by a
//   randomized run checked every cycle against a transaction-level model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  mem_access_unit_if bus ();

  mem_access_unit u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int nbytes(mem_op_t op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: return 1;
      MOP_LH, MOP_LHU, MOP_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit is_st(mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  function automatic bit misaligned(mem_op_t op, logic [31:0] a);
    return (a % nbytes(op)) != 0;
  endfunction

  function automatic logic [31:0] exp_size(mem_op_t op);
    int n = nbytes(op);
    if (n == 1) return 32'(MSIZE1);
    if (n == 2) return 32'(MSIZE2);
    return 32'(MSIZE4);
  endfunction

  function automatic logic [31:0] exp_strobe(mem_op_t op, logic [31:0] a);
    int n = nbytes(op);
    logic [31:0] r;
    if (!is_st(op)) return 32'd0;
    r = 32'(((1 << n) - 1) << (a % 4));
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(mem_op_t op, logic [31:0] w);
    int n = nbytes(op);
    if (!is_st(op)) return 32'd0;
    if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(mem_op_t op, logic [31:0] a, logic [31:0] d);
    longint unsigned v, span;
    int n = nbytes(op);
    v    = {32'd0, d} >> (8 * (a % 4));
    span = 64'd1 << (8 * n);
    v    = v % span;
    if ((op == MOP_LB || op == MOP_LH) && v >= span / 2)
      v = v + (64'h1_0000_0000 - span);
    return v[31:0];
  endfunction

  // ---------------- model state ----------------
  bit          m_busy, m_acc, m_drop, m_hold, m_fin;
  mem_op_t     m_q_op;
  logic [31:0] m_q_addr, m_q_wdata;
  logic [31:0] e_valid, e_addr, e_size, e_strobe, e_data;
  logic [31:0] e_stall, e_done, e_rdata, e_adel, e_ades;

  initial begin
    m_busy = 0; m_acc = 0; m_drop = 0; m_hold = 0;
    m_q_op = MOP_LB; m_q_addr = 0; m_q_wdata = 0;
  end

  task automatic expect_req(mem_op_t op, logic [31:0] a, logic [31:0] w);
    e_valid  = 1;
    e_addr   = a;
    e_size   = exp_size(op);
    e_strobe = exp_strobe(op, a);
    e_data   = exp_wdata(op, w);
  endtask

  // Compare process: inputs are stable from posedge+1; evaluate mid-cycle.
  always @(negedge clk) begin
    e_valid = 0; e_addr = 0; e_size = 0; e_strobe = 0; e_data = 0;
    e_stall = 0; e_done = 0; e_rdata = 0; e_adel = 0; e_ades = 0;
    if (resetn !== 1'b1) begin
      m_busy = 0; m_acc = 0; m_drop = 0;
    end else if (!m_busy) begin
      if (bus.in_valid && !bus.flush) begin
        if (misaligned(bus.in_op, bus.in_addr)) begin
          e_done = 1;
          e_adel = !is_st(bus.in_op);
          e_ades = is_st(bus.in_op);
        end else begin
          expect_req(bus.in_op, bus.in_addr, bus.in_wdata);
          if (bus.dresp.addr_ok && bus.dresp.data_ok) begin
            e_done  = 1;
            e_rdata = is_st(bus.in_op) ? 32'd0 : exp_load(bus.in_op, bus.in_addr, bus.dresp.data);
          end else begin
            m_busy = 1; m_acc = bus.dresp.addr_ok; m_drop = 0;
            m_q_op = bus.in_op; m_q_addr = bus.in_addr; m_q_wdata = bus.in_wdata;
          end
        end
      end
      e_stall = (bus.in_valid && !bus.flush && !e_done) ? 1 : 0;
    end else begin
      m_fin = 0;
      if (!m_acc) begin
        expect_req(m_q_op, m_q_addr, m_q_wdata);
        if (bus.dresp.addr_ok) begin
          if (bus.dresp.data_ok) m_fin = 1;
          else m_acc = 1;
        end
      end else if (bus.dresp.data_ok) begin
        m_fin = 1;
      end
      if (m_fin) begin
        m_busy = 0;
        if (!(m_drop || bus.flush)) begin
          e_done  = 1;
          e_rdata = is_st(m_q_op) ? 32'd0 : exp_load(m_q_op, m_q_addr, bus.dresp.data);
        end
        m_drop = 0;
      end else begin
        m_drop = m_drop || bus.flush;
      end
      e_stall = e_done ? 0 : 1;
    end

    chk("dreq.valid",  bus.dreq.valid,  e_valid);
    chk("dreq.addr",   bus.dreq.addr,   e_addr);
    chk("dreq.size",   bus.dreq.size,   e_size);
    chk("dreq.strobe", bus.dreq.strobe, e_strobe);
    chk("dreq.data",   bus.dreq.data,   e_data);
    chk("stall",       bus.stall,       e_stall);
    chk("done",        bus.done,        e_done);
    chk("rdata",       bus.rdata,       e_rdata);
    chk("adel",        bus.adel,        e_adel);
    chk("ades",        bus.ades,        e_ades);

    m_hold = (resetn === 1'b1) && e_stall[0] && bus.in_valid && !bus.flush;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rn, input bit v, input mem_op_t op, input logic [31:0] a,
                       input logic [31:0] w, input bit fl, input bit ak, input bit dk,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    resetn       = rn;
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_addr  = a;
    bus.in_wdata = w;
    bus.flush    = fl;
    bus.dresp    = '{addr_ok: ak, data_ok: dk, data: d};
    #2;
  endtask

  initial begin
    mem_op_t     r_op;
    logic [31:0] r_a;
    bit          pending;

    resetn = 0;
    bus.in_valid = 0; bus.in_op = MOP_LB; bus.in_addr = 0; bus.in_wdata = 0;
    bus.flush = 0; bus.dresp = '0;

    // Reset holds every output at zero even with a live instruction present.
    drive(0, 1, MOP_LW, 32'h8000_0010, 0, 0, 1, 1, 32'h1234_5678);
    chk("rst_valid", bus.dreq.valid, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rdata", bus.rdata, 0);
    drive(0, 0, MOP_LB, 0, 0, 0, 0, 0, 0);

    // Zero-latency LW
    drive(1, 1, MOP_LW, 32'h8000_0010, 0, 0, 1, 1, 32'hDEAD_BEEF);
    chk("lw_fast_valid", bus.dreq.valid, 1);
    chk("lw_fast_done",  bus.done, 1);
    chk("lw_fast_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("lw_fast_stall", bus.stall, 0);

    // Byte extraction with sign / zero extension
    drive(1, 1, MOP_LB, 32'h8000_0013, 0, 0, 1, 1, 32'h8000_0000);
    chk("lb_rdata", bus.rdata, 32'hFFFF_FF80);
    drive(1, 1, MOP_LBU, 32'h8000_0013, 0, 0, 1, 1, 32'h8000_0000);
    chk("lbu_rdata", bus.rdata, 32'h0000_0080);

    // SH with addr_ok delayed: request stable for 4 cycles
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, MOP_SH, 32'h8000_0002, 32'h0000_1234, 0, (i == 3), 0, $urandom);
      chk("sh_valid",  bus.dreq.valid, 1);
      chk("sh_addr",   bus.dreq.addr, 32'h8000_0002);
      chk("sh_strobe", bus.dreq.strobe, 4'b1100);
      chk("sh_data",   bus.dreq.data, 32'h1234_1234);
      chk("sh_size",   bus.dreq.size, MSIZE2);
      chk("sh_stall",  bus.stall, 1);
    end
    drive(1, 1, MOP_SH, 32'h8000_0002, 32'h0000_1234, 0, 0, 1, 32'hFFFF_FFFF);
    chk("sh_done",  bus.done, 1);
    chk("sh_stall_end", bus.stall, 0);
    chk("sh_wait_valid", bus.dreq.valid, 0);
    chk("sh_rdata", bus.rdata, 0);

    // Address errors
    drive(1, 1, MOP_LW, 32'h8000_0006, 0, 0, 0, 0, 0);
    chk("adel", bus.adel, 1);
    chk("adel_done", bus.done, 1);
    chk("adel_valid", bus.dreq.valid, 0);
    chk("adel_stall", bus.stall, 0);
    drive(1, 1, MOP_SW, 32'h8000_0006, 32'h55AA_55AA, 0, 0, 0, 0);
    chk("ades", bus.ades, 1);
    chk("ades_adel", bus.adel, 0);
    chk("ades_done", bus.done, 1);

    // Flush in IDLE suppresses issue
    drive(1, 1, MOP_LW, 32'h8000_0040, 0, 1, 1, 1, 32'h0BAD_0BAD);
    chk("flush_idle_valid", bus.dreq.valid, 0);
    chk("flush_idle_done",  bus.done, 0);
    chk("flush_idle_stall", bus.stall, 0);

    // Flush while waiting for data: drained silently, next LW after drain
    drive(1, 1, MOP_LW, 32'h8000_0020, 0, 0, 1, 0, 0);
    chk("drop_acc_stall", bus.stall, 1);
    drive(1, 1, MOP_LW, 32'h8000_0020, 0, 1, 0, 0, 0);
    chk("drop_flush_stall", bus.stall, 1);
    drive(1, 1, MOP_LW, 32'h8000_0024, 0, 0, 0, 0, 0);
    chk("drop_nissue", bus.dreq.valid, 0);
    drive(1, 1, MOP_LW, 32'h8000_0024, 0, 0, 0, 1, 32'h9999_9999);
    chk("drop_done",  bus.done, 0);
    chk("drop_rdata", bus.rdata, 0);
    chk("drop_stall", bus.stall, 1);
    drive(1, 1, MOP_LW, 32'h8000_0024, 0, 0, 1, 1, 32'h1122_3344);
    chk("after_drain_valid", bus.dreq.valid, 1);
    chk("after_drain_addr",  bus.dreq.addr, 32'h8000_0024);
    chk("after_drain_rdata", bus.rdata, 32'h1122_3344);

    // Reset in REQ
    drive(1, 1, MOP_SW, 32'h8000_0030, 32'hA5A5_A5A5, 0, 0, 0, 0);
    chk("req_stall", bus.stall, 1);
    drive(0, 1, MOP_SW, 32'h8000_0030, 32'hA5A5_A5A5, 0, 1, 1, 0);
    chk("rst_req_valid", bus.dreq.valid, 0);
    chk("rst_req_stall", bus.stall, 0);
    drive(1, 0, MOP_LB, 0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", bus.dreq.valid, 0);
    chk("post_rst_stall", bus.stall, 0);
    chk("post_rst_done",  bus.done, 0);
    drive(1, 1, MOP_LW, 32'h8000_0040, 0, 0, 1, 1, 32'hCAFE_F00D);
    chk("post_rst_issue", bus.rdata, 32'hCAFE_F00D);

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      resetn = ($urandom % 300) != 0;
      if (!m_hold) begin
        r_op = mem_op_t'($urandom_range(0, 7));
        r_a  = $urandom;
        if (($urandom % 4) != 0) r_a = r_a & ~(32'(nbytes(r_op) - 1));
        bus.in_valid = ($urandom % 4) != 0;
        bus.in_op    = r_op;
        bus.in_addr  = r_a;
        bus.in_wdata = $urandom;
      end
      bus.flush = ($urandom % 12) == 0;
      pending = m_busy ? !m_acc
                       : (bus.in_valid && !bus.flush && !misaligned(bus.in_op, bus.in_addr));
      if (m_busy && m_acc) begin
        bus.dresp.addr_ok = $urandom % 2;
        bus.dresp.data_ok = ($urandom % 3) == 0;
      end else if (pending) begin
        bus.dresp.addr_ok = ($urandom % 3) == 0;
        bus.dresp.data_ok = bus.dresp.addr_ok && ($urandom % 2);
      end else begin
        bus.dresp.addr_ok = 0;
        bus.dresp.data_ok = 0;
      end
      bus.dresp.data = $urandom;
    end

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
